// File: rtl/adder_pkg.sv
// Shared definitions for the 128-bit adder operand path.
package adder_pkg;

  // Default stream word and operand widths.
  localparam int WORD_W_DEFAULT = 32;
  localparam int OP_W_DEFAULT   = 128;

  // Number of stream words that make up one operand.
  localparam int WORDS_PER_OP = OP_W_DEFAULT / WORD_W_DEFAULT;

  // Cycles from operands presented to sum/cout valid at the adder outputs.
  localparam int ADD_LATENCY_DEFAULT = 10;

  // Operand loader sequencing states.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_e;

endpackage

// File: rtl/latency_tracker.sv
// Valid-bit delay line: the output is the input delayed by exactly DEPTH
// flops. Used to align a result strobe with a fixed-latency pipeline.
module latency_tracker #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  output logic valid_out
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Next shift-register contents: new bit enters at stage 0.
  always_comb begin
    sr_d    = '0;
    sr_d[0] = valid_in;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  // Shift register; reset drops every in-flight valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid_out = sr_q[DEPTH-1];

endmodule

// File: rtl/adder_operand_loader.sv
// Assembles operand A then operand B from a word stream, presents them to
// the adder as registered buses, and flags when the adder result is ready.
module adder_operand_loader
  import adder_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEFAULT,
  parameter int OP_W        = OP_W_DEFAULT,
  parameter int ADD_LATENCY = ADD_LATENCY_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_cin,
  input  logic              clr,
  output logic [OP_W-1:0]   op_a,
  output logic [OP_W-1:0]   op_b,
  output logic              op_cin,
  output logic              op_issue,
  output logic              res_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  issue_count
);

  localparam int WORDS = OP_W / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OP_W-1:0]  shadow_a_q, shadow_a_d;
  logic [OP_W-1:0]  shadow_b_q, shadow_b_d;
  logic             shadow_cin_q, shadow_cin_d;
  logic [OP_W-1:0]  op_a_q, op_a_d;
  logic [OP_W-1:0]  op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic             op_issue_q, op_issue_d;
  logic [CNT_W-1:0] issue_count_q, issue_count_d;

  // Operand B as it will be once the final word lands this cycle.
  logic [OP_W-1:0]  b_full;
  logic             last_word;

  assign last_word = (idx_q == LAST_IDX);

  // Next-state, shadow capture and issue decision.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_a_d    = shadow_a_q;
    shadow_b_d    = shadow_b_q;
    shadow_cin_d  = shadow_cin_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    op_cin_d      = op_cin_q;
    op_issue_d    = 1'b0;
    issue_count_d = issue_count_q;

    b_full = shadow_b_q;
    b_full[OP_W-1 -: WORD_W] = in_data;

    case (state_q)
      LOAD_A: begin
        // clr takes priority over a word offered in the same cycle.
        if (clr) begin
          idx_d = '0;
        end else if (in_valid) begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              shadow_a_d[k*WORD_W +: WORD_W] = in_data;
            end
          end
          if (idx_q == '0) begin
            shadow_cin_d = in_cin;
          end
          if (last_word) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      LOAD_B: begin
        if (clr) begin
          idx_d   = '0;
          state_d = LOAD_A;
        end else if (in_valid) begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              shadow_b_d[k*WORD_W +: WORD_W] = in_data;
            end
          end
          if (last_word) begin
            // Final word bypasses the shadow so the pair issues this edge.
            idx_d      = '0;
            op_a_d     = shadow_a_q;
            op_b_d     = b_full;
            op_cin_d   = shadow_cin_q;
            op_issue_d = 1'b1;
            state_d    = ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ISSUE: begin
        // Single-cycle state; clr is deliberately not looked at here.
        issue_count_d = issue_count_q + CNT_W'(1);
        state_d       = LOAD_A;
      end

      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD_A;
      idx_q         <= '0;
      shadow_a_q    <= '0;
      shadow_b_q    <= '0;
      shadow_cin_q  <= 1'b0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_cin_q      <= 1'b0;
      op_issue_q    <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_a_q    <= shadow_a_d;
      shadow_b_q    <= shadow_b_d;
      shadow_cin_q  <= shadow_cin_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      op_cin_q      <= op_cin_d;
      op_issue_q    <= op_issue_d;
      issue_count_q <= issue_count_d;
    end
  end

  // Result strobe follows the issue pulse through the adder's latency.
  latency_tracker #(
    .DEPTH (ADD_LATENCY)
  ) u_latency_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (op_issue_q),
    .valid_out (res_valid)
  );

  assign in_ready    = (state_q != ISSUE);
  assign busy        = (idx_q != '0) || (state_q != LOAD_A);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_cin      = op_cin_q;
  assign op_issue    = op_issue_q;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader with an issue/result scoreboard.
module tb_adder_operand_loader;
  import adder_pkg::*;

  localparam int WORD_W = 32;
  localparam int OP_W   = 128;
  localparam int LAT    = ADD_LATENCY_DEFAULT;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_cin;
  logic              clr;
  logic [OP_W-1:0]   op_a;
  logic [OP_W-1:0]   op_b;
  logic              op_cin;
  logic              op_issue;
  logic              res_valid;
  logic              busy;
  logic [CNT_W-1:0]  issue_count;

  adder_operand_loader #(
    .WORD_W      (WORD_W),
    .OP_W        (OP_W),
    .ADD_LATENCY (LAT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_cin      (in_cin),
    .clr         (clr),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .op_issue    (op_issue),
    .res_valid   (res_valid),
    .busy        (busy),
    .issue_count (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the pipelined adder fed by the DUT buses.
  logic [OP_W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {{OP_W{1'b0}}, op_cin};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
  } iss_t;

  typedef struct {
    logic [OP_W:0] sum;
    int            due;
  } res_t;

  iss_t iss_q[$];
  res_t res_q[$];

  int              tests_run    = 0;
  int              tests_failed = 0;
  logic [CNT_W-1:0] exp_count   = '0;
  bit              cnt_pending  = 0;
  int              last_issue_cyc = -1;
  int              issues_seen  = 0;
  logic [OP_W-1:0] cur_a        = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag, input int obs, input int exp);
    tests_run++;
    tests_failed++;
    $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Watches DUT outputs every negedge and reconciles them with the queues.
  task automatic monitor();
    iss_t e;
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      chk("in_ready_vs_issue", in_ready, !op_issue);
      if (op_issue) begin
        if (iss_q.size() == 0) begin
          fail_now("unexpected_issue", 1, 0);
        end else begin
          e = iss_q.pop_front();
          chk("op_a", op_a, e.a);
          chk("op_b", op_b, e.b);
          chk("op_cin", op_cin, e.cin);
          cur_a = e.a;
          r.sum = {1'b0, e.a} + {1'b0, e.b} + {{OP_W{1'b0}}, e.cin};
          r.due = cyc + LAT;
          res_q.push_back(r);
          $display("[TB] issue cyc=%0d a=%h b=%h cin=%0b", cyc, op_a, op_b, op_cin);
        end
        chk("issue_count_pre", issue_count, exp_count);
        exp_count      = exp_count + 1'b1;
        cnt_pending    = 1;
        last_issue_cyc = cyc;
        issues_seen++;
      end else if (cnt_pending) begin
        chk("issue_count", issue_count, exp_count);
        $display("[TB] issue_count now %0d", issue_count);
        cnt_pending = 0;
      end
      if (res_valid) begin
        if (res_q.size() == 0) begin
          fail_now("unexpected_res_valid", cyc, -1);
        end else begin
          r = res_q.pop_front();
          chk("res_valid_cycle", cyc, r.due);
          chk("adder_result", pipe[LAT-1], r.sum);
          $display("[TB] result cyc=%0d cout=%0b s=%h", cyc, pipe[LAT-1][OP_W], pipe[LAT-1][OP_W-1:0]);
        end
      end else if (res_q.size() != 0 && res_q[0].due <= cyc) begin
        fail_now("missing_res_valid", cyc, res_q[0].due);
        void'(res_q.pop_front());
      end
    end
  endtask

  // Offers one word and holds it until it is accepted (bounded wait).
  task automatic send_word(input logic [WORD_W-1:0] w, input logic cin);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_cin   = cin;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        fail_now("ready_timeout", waited, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Idle cycles with in_valid low, checking the held state on each.
  task automatic gap_cycles(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("busy_in_gap", busy, 1'b1);
      chk("op_a_held", op_a, cur_a);
      @(posedge clk); #1;
    end
  endtask

  // Full operand pair; returns #1 after the issue edge.
  task automatic load_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                           input logic cin, input int max_gap);
    iss_t e;
    logic [OP_W-1:0] av;
    logic [OP_W-1:0] bv;
    e.a = a; e.b = b; e.cin = cin;
    iss_q.push_back(e);
    av = a;
    bv = b;
    for (int k = 0; k < 4; k++) begin
      send_word(av[k*WORD_W +: WORD_W], cin);
      if (max_gap > 0) gap_cycles($urandom_range(0, max_gap));
    end
    for (int k = 0; k < 4; k++) begin
      send_word(bv[k*WORD_W +: WORD_W], 1'b0);
      if (max_gap > 0 && k < 3) gap_cycles($urandom_range(0, max_gap));
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int c0;
  int seen0;
  logic [OP_W-1:0] ra;
  logic [OP_W-1:0] rb;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cin = 1'b0; clr = 1'b0;
    fork
      monitor();
    join_none

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_a", op_a, '0);
    chk("rst_op_b", op_b, '0);
    chk("rst_op_cin", op_cin, 1'b0);
    chk("rst_op_issue", op_issue, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_issue_count", issue_count, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load, then carry propagation with no gap in between.
    c0 = cyc;
    load_pair(128'h1, 128'hFFFF_FFFF, 1'b0, 0);
    @(negedge clk); #1;
    chk("first_issue_latency", last_issue_cyc - c0, 8);
    c0 = last_issue_cyc;
    load_pair({OP_W{1'b1}}, '0, 1'b1, 0);
    @(negedge clk); #1;
    chk("issue_spacing", last_issue_cyc - c0, 9);
    idle(14);

    // Stalls between words.
    ra = {32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    rb = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    load_pair(ra, rb, 1'b1, 3);
    idle(14);

    // clr abort in LOAD_A with a word on the bus, then in LOAD_B.
    seen0 = issues_seen;
    send_word(32'hAAAA_0000, 1'b1);
    send_word(32'hAAAA_0001, 1'b1);
    in_valid = 1'b1; in_data = 32'hBAD0_BAD0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_clr_a", busy, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send_word(32'h5A00_0000 + k, 1'b0);
    in_valid = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("busy_after_clr_b", busy, 1'b0);
    @(posedge clk); #1;
    ra = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    rb = {32'h0000_0040, 32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    load_pair(ra, rb, 1'b0, 0);
    idle(14);
    chk("clr_single_issue", issues_seen - seen0, 1);

    // Reset while a result is still in flight.
    load_pair({OP_W{1'b1}}, 128'h5, 1'b0, 0);
    idle(3);
    rst_n = 1'b0;
    res_q.delete();
    exp_count   = '0;
    cnt_pending = 0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_op_a", op_a, '0);
    chk("post_rst_op_b", op_b, '0);
    chk("post_rst_issue_count", issue_count, '0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    cur_a = '0;
    @(posedge clk); #1;
    idle(14);

    // Five more issues across the counter wrap.
    for (int n = 0; n < 5; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      load_pair(ra, rb, 1'($urandom_range(0, 1)), 0);
    end
    idle(14);
    chk("issues_left", iss_q.size(), 0);
    chk("results_left", res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
